branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Other end of the BTB: tracks in-flight fetch predictions in order, checks each against the
//  WB-stage branch outcome, and on mismatch pulses flush with the corrected PC.
//  Sends BTB write/invalidate requests over a valid/ready channel. Sits between IF (enqueue) and WB (resolve).
// PARAMETERS
//  DEPTH  4   max in-flight prediction records (power of 2, >=2)
//  WIDTH  16  address width (lc3b_word)
// PORTS
//  clk                in   1   clock
//  reset              in   1   synchronous, active-high reset
//  pred_valid         in   1   IF presents a prediction record
//  pred_pc            in   16  fetched instruction PC
//  pred_taken         in   1   BTB hit (predicted taken)
//  pred_target        in   16  BTB predicted target
//  pred_ready         out  1   queue not full; IF stalls when low
//  res_valid          in   1   WB resolves the oldest in-flight record
//  res_is_branch      in   1   resolved instr is a control transfer
//  res_taken          in   1   actual direction
//  res_target         in   16  actual target
//  flush              out  1   one-cycle mispredict pulse
//  redirect_pc        out  16  corrected PC, valid while flush=1
//  btb_wr_valid       out  1   BTB update request
//  btb_wr_ready       in   1   BTB accepts request
//  btb_wr_pc          out  16  entry PC (tag/index source)
//  btb_wr_target      out  16  new target
//  btb_wr_invalidate  out  1   1 = clear entry; 0 = allocate/overwrite
//  wr_drop            out  1   one-cycle pulse: pending request overwritten
//  err_underflow      out  1   sticky: res_valid seen with empty queue
//  mispredict_count   out  16  saturating mispredict counter
// BEHAVIOUR
//  - Reset: queue empty, all outputs 0 (pred_ready=1); pending BTB request discarded.
//  - Queue: circular FIFO, DEPTH records {pc,taken,target}; ptrs wrap mod DEPTH; pred_ready=(occ<DEPTH), state-only.
//  - Enqueue when pred_valid&pred_ready; pop head when res_valid&occ>0. Both in same cycle: occ unchanged.
//  - res_valid with occ==0: no pop, no flush, no write; err_underflow set until reset.
//  - Mispredict (head H): res_is_branch ? (H.taken!=res_taken | (res_taken & H.target!=res_target)) : H.taken.
//  - Correct PC: (res_is_branch&res_taken) ? res_target : H.pc+2 (mod 2^16, 0xFFFE->0x0000).
//  - On mispredict at edge N: queue cleared (occ=0), same-cycle enqueue discarded; in cycle N+1
//    flush=1, redirect_pc=correct PC; flush low in N+2 unless another mispredict. redirect_pc holds last value.
//  - mispredict_count +1 per mispredict, saturates at 0xFFFF.
//  - BTB request needed: res_is_branch&res_taken&(!H.taken|H.target!=res_target) -> write {H.pc,res_target,inv=0};
//    H.taken&(!res_is_branch|!res_taken) -> write {H.pc,H.target,inv=1}. Correct predictions: none.
//  - BTB FSM: IDLE -> PEND on new request (btb_wr_valid=1 in cycle after resolve). PEND: payload stable
//    until btb_wr_valid&btb_wr_ready; then IDLE, or stay PEND loading a same-cycle new request.
//  - New request in PEND while ready=0: newest replaces payload, wr_drop=1 for one cycle.
//  - Reset mid-request: btb_wr_valid low next cycle, no completion required.
// TESTING
//  1. Enqueue pc 0x3000 taken=0; resolve branch taken target 0x3020 -> next cycle flush=1, redirect_pc=0x3020,
//     btb_wr_valid=1 {0x3000,0x3020,inv=0}, mispredict_count=1, occ=0.
//  2. Enqueue pc 0x3040 taken=1 tgt 0x3100; resolve taken 0x3100 -> flush=0, btb_wr_valid=0, occ 1->0.
//  3. Enqueue 4 records -> pred_ready=0, 5th pred_valid ignored; resolve correct -> occ=3, pred_ready=1;
//     resolve+enqueue same cycle -> occ stays 3.
//  4. pc 0xFFFE predicted taken tgt 0x0400, resolve not-taken -> redirect_pc=0x0000, request {0xFFFE,0x0400,inv=1}.
//  5. Hold btb_wr_ready=0 3 cycles after test 1: payload stable; second mispredict -> wr_drop pulse,
//     payload = new request; ready=1 -> btb_wr_valid low next cycle.
//  6. res_valid with empty queue -> err_underflow=1, no flush; assert reset with request pending -> all outputs 0 next cycle.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight BTB predictions in fetch order, resolves the oldest against the WB outcome,
// flushes with the corrected PC on a mispredict and sends BTB update requests over valid/ready.
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pred_valid,
   input  logic [WIDTH-1:0] pred_pc,
   input  logic             pred_taken,
   input  logic [WIDTH-1:0] pred_target,
   output logic             pred_ready,
   input  logic             res_valid,
   input  logic             res_is_branch,
   input  logic             res_taken,
   input  logic [WIDTH-1:0] res_target,
   output logic             flush,
   output logic [WIDTH-1:0] redirect_pc,
   output logic             btb_wr_valid,
   input  logic             btb_wr_ready,
   output logic [WIDTH-1:0] btb_wr_pc,
   output logic [WIDTH-1:0] btb_wr_target,
   output logic             btb_wr_invalidate,
   output logic             wr_drop,
   output logic             err_underflow,
   output logic [15:0]      mispredict_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic {IDLE, PEND} btb_state_t;

   logic [WIDTH-1:0] q_pc     [DEPTH];
   logic             q_taken  [DEPTH];
   logic [WIDTH-1:0] q_target [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   occ;

   logic             enq, pop, mispredict;
   logic             req_alloc, req_inv, new_req;
   logic [WIDTH-1:0] h_pc, h_target, correct_pc, req_target;
   logic             h_taken;
   btb_state_t       state, state_next;

   assign pred_ready = (occ < OCC_FULL);
   assign h_pc       = q_pc[head];
   assign h_taken    = q_taken[head];
   assign h_target   = q_target[head];

   // Resolution of the head record and the BTB correction it implies.
   always_comb begin
      enq        = pred_valid && pred_ready;
      pop        = res_valid && (occ != '0);
      mispredict = 1'b0;
      req_alloc  = 1'b0;
      req_inv    = 1'b0;
      correct_pc = h_pc + WIDTH'(2);
      req_target = h_target;
      if (pop) begin
         if (res_is_branch)
            mispredict = (h_taken != res_taken) || (res_taken && (h_target != res_target));
         else
            mispredict = h_taken;
         if (res_is_branch && res_taken)
            correct_pc = res_target;
         req_alloc = res_is_branch && res_taken && (!h_taken || (h_target != res_target));
         req_inv   = h_taken && (!res_is_branch || !res_taken);
         if (req_alloc)
            req_target = res_target;
      end
      new_req = req_alloc || req_inv;
   end

   always_ff @(posedge clk) begin
      if (enq && !mispredict) begin
         q_pc[tail]     <= pred_pc;
         q_taken[tail]  <= pred_taken;
         q_target[tail] <= pred_target;
      end
   end

   // A mispredict empties the queue and drops any record fetched down the wrong path.
   always_ff @(posedge clk) begin
      if (reset || mispredict) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (enq)
            tail <= tail + PTR_W'(1);
         if (pop)
            head <= head + PTR_W'(1);
         if (enq && !pop)
            occ <= occ + (PTR_W+1)'(1);
         else if (!enq && pop)
            occ <= occ - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flush            <= 1'b0;
         redirect_pc      <= '0;
         mispredict_count <= '0;
         err_underflow    <= 1'b0;
      end else begin
         flush <= mispredict;
         if (mispredict) begin
            redirect_pc <= correct_pc;
            if (mispredict_count != 16'hFFFF)
               mispredict_count <= mispredict_count + 16'd1;
         end
         if (res_valid && (occ == '0))
            err_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (new_req) state_next = PEND;
         PEND: if (!new_req && btb_wr_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      btb_wr_valid = (state == PEND);
   end

   // The newest request always wins; an unaccepted older one is reported as dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         btb_wr_pc         <= '0;
         btb_wr_target     <= '0;
         btb_wr_invalidate <= 1'b0;
         wr_drop           <= 1'b0;
      end else begin
         wr_drop <= new_req && (state == PEND) && !btb_wr_ready;
         if (new_req) begin
            btb_wr_pc         <= h_pc;
            btb_wr_target     <= req_target;
            btb_wr_invalidate <= req_inv;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;

   typedef struct {
      logic [15:0] pc;
      logic        taken;
      logic [15:0] target;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset, pred_valid, pred_taken, res_valid, res_is_branch, res_taken, btb_wr_ready;
   logic [15:0] pred_pc, pred_target, res_target;
   logic        pred_ready, flush, btb_wr_valid, btb_wr_invalidate, wr_drop, err_underflow;
   logic [15:0] redirect_pc, btb_wr_pc, btb_wr_target, mispredict_count;

   int n_cmp = 0;
   int n_fail = 0;

   rec_t        mq[$];
   logic        m_flush, m_pend, m_inv, m_drop, m_err;
   logic [15:0] m_redirect, m_count, m_wpc, m_wtgt;

   branch_resolve_unit #(.DEPTH(DEPTH), .WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
      .res_target(res_target), .flush(flush), .redirect_pc(redirect_pc),
      .btb_wr_valid(btb_wr_valid), .btb_wr_ready(btb_wr_ready), .btb_wr_pc(btb_wr_pc),
      .btb_wr_target(btb_wr_target), .btb_wr_invalidate(btb_wr_invalidate),
      .wr_drop(wr_drop), .err_underflow(err_underflow), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // Next-cycle expectations from the current inputs and the model's pre-edge state.
   task automatic modelStep();
      rec_t        h;
      logic        mis, req, inv;
      logic [15:0] npc, rtgt;
      logic        ready;
      if (reset) begin
         mq.delete();
         m_flush = 0; m_pend = 0; m_inv = 0; m_drop = 0; m_err = 0;
         m_redirect = 0; m_count = 0; m_wpc = 0; m_wtgt = 0;
         return;
      end
      ready = (mq.size() < DEPTH);
      mis = 0; req = 0; inv = 0; rtgt = 0; npc = 0;
      if (res_valid && mq.size() == 0) m_err = 1;
      if (res_valid && mq.size() > 0) begin
         h = mq[0];
         if (res_is_branch)
            mis = (h.taken != res_taken) || (res_taken && h.target != res_target);
         else
            mis = h.taken;
         npc = (res_is_branch && res_taken) ? res_target : h.pc + 16'd2;
         if (res_is_branch && res_taken && (!h.taken || h.target != res_target)) begin
            req = 1; inv = 0; rtgt = res_target;
         end else if (h.taken && (!res_is_branch || !res_taken)) begin
            req = 1; inv = 1; rtgt = h.target;
         end
      end
      m_drop = req && m_pend && !btb_wr_ready;
      if (m_pend && btb_wr_ready) m_pend = 0;
      if (req) begin
         m_pend = 1; m_wpc = h.pc; m_wtgt = rtgt; m_inv = inv;
      end
      m_flush = mis;
      if (mis) begin
         m_redirect = npc;
         if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
         mq.delete();
      end else begin
         if (res_valid && mq.size() > 0) void'(mq.pop_front());
         if (pred_valid && ready) mq.push_back('{pred_pc, pred_taken, pred_target});
      end
   endtask

   task automatic checkOutput();
      cmp("pred_ready", 16'(pred_ready), 16'(mq.size() < DEPTH));
      cmp("flush", 16'(flush), 16'(m_flush));
      cmp("redirect_pc", redirect_pc, m_redirect);
      cmp("btb_wr_valid", 16'(btb_wr_valid), 16'(m_pend));
      cmp("btb_wr_pc", btb_wr_pc, m_wpc);
      cmp("btb_wr_target", btb_wr_target, m_wtgt);
      cmp("btb_wr_invalidate", 16'(btb_wr_invalidate), 16'(m_inv));
      cmp("wr_drop", 16'(wr_drop), 16'(m_drop));
      cmp("err_underflow", 16'(err_underflow), 16'(m_err));
      cmp("mispredict_count", mispredict_count, m_count);
   endtask

   task automatic applyStimulus(input logic rst, input logic pv, input logic [15:0] ppc,
                                input logic ptk, input logic [15:0] ptgt, input logic rv,
                                input logic rb, input logic rt, input logic [15:0] rtg,
                                input logic rdy);
      reset = rst; pred_valid = pv; pred_pc = ppc; pred_taken = ptk; pred_target = ptgt;
      res_valid = rv; res_is_branch = rb; res_taken = rt; res_target = rtg; btb_wr_ready = rdy;
      modelStep();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   function automatic logic [15:0] pickTarget(input int k);
      case (k)
         0: return 16'h3020;
         1: return 16'h3100;
         2: return 16'h0400;
         default: return 16'h3008;
      endcase
   endfunction

   initial begin
      logic        rv, rb, rt;
      logic [15:0] rtg;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cmp("reset pred_ready literal", 16'(pred_ready), 16'd1);
      cmp("reset count literal", mispredict_count, 16'd0);

      // Not-taken prediction resolved taken: flush, redirect, allocate request.
      applyStimulus(0, 1, 16'h3000, 0, 16'h0000, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 16'h3020, 0);
      cmp("t1 flush literal", 16'(flush), 16'd1);
      cmp("t1 redirect literal", redirect_pc, 16'h3020);
      cmp("t1 wr_valid literal", 16'(btb_wr_valid), 16'd1);
      cmp("t1 wr_pc literal", btb_wr_pc, 16'h3000);
      cmp("t1 wr_target literal", btb_wr_target, 16'h3020);
      cmp("t1 count literal", mispredict_count, 16'd1);
      repeat (3) idle(0);
      cmp("t5 payload stable literal", btb_wr_pc, 16'h3000);

      // Wrap-around redirect and invalidate while the previous request is still stalled.
      applyStimulus(0, 1, 16'hFFFE, 1, 16'h0400, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 0);
      cmp("t4 redirect literal", redirect_pc, 16'h0000);
      cmp("t5 wr_drop literal", 16'(wr_drop), 16'd1);
      cmp("t4 wr_pc literal", btb_wr_pc, 16'hFFFE);
      cmp("t4 wr_target literal", btb_wr_target, 16'h0400);
      cmp("t4 wr_inv literal", 16'(btb_wr_invalidate), 16'd1);
      idle(1);
      cmp("t5 wr_valid drops literal", 16'(btb_wr_valid), 16'd0);
      cmp("t5 wr_drop one pulse literal", 16'(wr_drop), 16'd0);

      // Correctly predicted taken branch: no flush, no request.
      applyStimulus(0, 1, 16'h3040, 1, 16'h3100, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 16'h3100, 1);
      cmp("t2 flush literal", 16'(flush), 16'd0);
      cmp("t2 wr_valid literal", 16'(btb_wr_valid), 16'd0);

      // Fill the queue, then resolve and enqueue around the full boundary.
      for (int i = 0; i < 5; i++)
         applyStimulus(0, 1, 16'h1000 + 16'(i * 2), 0, 0, 0, 0, 0, 0, 1);
      cmp("t3 full literal", 16'(pred_ready), 16'd0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      cmp("t3 not full literal", 16'(pred_ready), 16'd1);
      applyStimulus(0, 1, 16'h1010, 0, 0, 1, 0, 0, 0, 1);
      cmp("t3 occ held literal", 16'(pred_ready), 16'd1);
      applyStimulus(0, 1, 16'h1012, 0, 0, 0, 0, 0, 0, 1);
      cmp("t3 refill literal", 16'(pred_ready), 16'd0);

      // Underflow, then reset with a request pending.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 16'h2222, 0);
      cmp("t6 underflow literal", 16'(err_underflow), 16'd1);
      cmp("t6 no flush literal", 16'(flush), 16'd0);
      applyStimulus(0, 1, 16'h3000, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 16'h3020, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cmp("t6 reset wr_valid literal", 16'(btb_wr_valid), 16'd0);
      cmp("t6 reset err literal", 16'(err_underflow), 16'd0);

      for (int c = 0; c < 3000; c++) begin
         rv = ($urandom_range(0, 1) == 1);
         if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
            rb = 1; rt = mq[0].taken; rtg = mq[0].target;
         end else begin
            rb = ($urandom_range(0, 3) != 0);
            rt = 1'($urandom_range(0, 1));
            rtg = pickTarget($urandom_range(0, 3));
         end
         applyStimulus(($urandom_range(0, 299) == 0),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'h3000 + 16'($urandom_range(0, 15) * 2),
                       1'($urandom_range(0, 1)),
                       pickTarget($urandom_range(0, 3)),
                       rv, rb, rt, rtg,
                       ($urandom_range(0, 1) == 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
